// File: rtl/fifo_sync_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_sync_ctrl
// Single-clock pointer/flag controller for a first-word-fall-through FIFO
// built around an external fifomem (n-bit addresses, 2**n entries).
//
// Parameters:
//   n        address width, depth = 2**n
//   AF_LEVEL almost_full  asserts when count >= AF_LEVEL (1..2**n)
//   AE_LEVEL almost_empty asserts when count <= AE_LEVEL (0..2**n-1)
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   winc         write request (requester drives fifomem wdata same cycle)
//   rinc         read request, pops the head entry shown on fifomem rdata
//   wclken       memory write enable = winc & ~full
//   waddr/raddr  memory write/read addresses
//   full/empty   occupancy flags
//   almost_full  / almost_empty  programmable threshold flags
//   count        occupancy 0..2**n
//
// Optional feature, macro FIFO_SYNC_ERR_EN:
//   ovf      sticky, set after a write attempted while full
//   udf      sticky, set after a read attempted while empty
//   err_clr  clears ovf/udf on the next edge; a same-cycle set wins
// ---------------------------------------------------------------------------
module fifo_sync_ctrl #(
    parameter int n        = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         winc,
    input  logic         rinc,
    output logic         wclken,
    output logic [n-1:0] waddr,
    output logic [n-1:0] raddr,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [n:0]   count
`ifdef FIFO_SYNC_ERR_EN
    ,
    output logic         ovf,
    output logic         udf,
    input  logic         err_clr
`endif
);

    localparam logic [n:0] AF_THR = (n+1)'(AF_LEVEL);
    localparam logic [n:0] AE_THR = (n+1)'(AE_LEVEL);

    // Binary pointers with one extra wrap bit to tell full from empty.
    logic [n:0] wptr;
    logic [n:0] rptr;
    logic       wr_ok;
    logic       rd_ok;

    assign wr_ok = winc & ~full;
    assign rd_ok = rinc & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
        end
    end

    // All flags decode from registered pointers only.
    always_comb begin
        empty        = (wptr == rptr);
        full         = (wptr[n] != rptr[n]) && (wptr[n-1:0] == rptr[n-1:0]);
        count        = wptr - rptr;
        almost_full  = (count >= AF_THR);
        almost_empty = (count <= AE_THR);
        wclken       = wr_ok;
        waddr        = wptr[n-1:0];
        raddr        = rptr[n-1:0];
    end

`ifdef FIFO_SYNC_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (winc && full)  ovf <= 1'b1;
            else if (err_clr)  ovf <= 1'b0;
            if (rinc && empty) udf <= 1'b1;
            else if (err_clr)  udf <= 1'b0;
        end
    end
`endif

endmodule
